// File: rtl/shift_sequencer.sv
// shift_sequencer: command sequencer driving an external 4-bit universal shift register.
// The sequence is load operand, shift `amount` times (saturated to 4), then capture the result.
// Optional build macro SHIFT_SEQ_ARITH_EN adds an `arith` input.
// When present, a logical right shift fills with the latched operand sign bit.
module shift_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dir,
  input  logic       mode,
`ifdef SHIFT_SEQ_ARITH_EN
  input  logic       arith,
`endif
  input  logic [2:0] amount,
  input  logic [3:0] operand,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       carry,
  output logic       sr_s1,
  output logic       sr_s0,
  output logic       sr_enable,
  output logic [3:0] sr_parallelin,
  output logic       sr_serialinr,
  output logic       sr_serialinl,
  input  logic [3:0] sr_parallelout,
  input  logic       sr_serialoutr,
  input  logic       sr_serialoutl
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       mode_q, mode_d;
  logic [3:0] operand_q, operand_d;
  logic [3:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       done_q, done_d;
  logic [1:0] sr_sel;
  logic       right_fill;

`ifdef SHIFT_SEQ_ARITH_EN
  logic arith_q, arith_d;

  // Latch the arithmetic-fill request with the rest of the command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) arith_q <= 1'b0;
    else          arith_q <= arith_d;
  end

  // Arithmetic right shifts replicate the sign bit of the operand as loaded.
  always_comb begin
    arith_d = arith_q;
    if (state_q == IDLE && start) arith_d = arith;
  end

  assign right_fill = arith_q ? operand_q[3] : 1'b0;
`else
  assign right_fill = 1'b0;
`endif

  // State and command registers; reset abandons any command in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      dir_q     <= 1'b0;
      mode_q    <= 1'b0;
      operand_q <= 4'd0;
      result_q  <= 4'd0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic and shift-register control for each phase.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    mode_d        = mode_q;
    operand_d     = operand_q;
    result_d      = result_q;
    carry_d       = carry_q;
    done_d        = 1'b0;
    sr_sel        = 2'b00;
    sr_enable     = 1'b0;
    sr_parallelin = 4'd0;
    sr_serialinr  = 1'b0;
    sr_serialinl  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d     = dir;
          mode_d    = mode;
          operand_d = operand;
          // Counts above 4 behave as 4: every bit has already left by then.
          cnt_d     = amount[2] ? 3'd4 : amount;
          carry_d   = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        sr_sel        = 2'b11;
        sr_enable     = 1'b1;
        sr_parallelin = operand_q;
        state_d       = (cnt_q != 3'd0) ? SHIFT : CAPTURE;
      end
      SHIFT: begin
        sr_enable = 1'b1;
        if (dir_q) begin
          sr_sel       = 2'b10;
          carry_d      = sr_serialoutl;
          sr_serialinl = mode_q ? sr_serialoutl : 1'b0;
        end else begin
          sr_sel       = 2'b01;
          carry_d      = sr_serialoutr;
          sr_serialinr = mode_q ? sr_serialoutr : right_fill;
        end
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = CAPTURE;
      end
      CAPTURE: begin
        sr_sel    = 2'b00;
        sr_enable = 1'b1;
        result_d  = sr_parallelout;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sr_s1  = sr_sel[1];
  assign sr_s0  = sr_sel[0];
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer with a behavioural 4-bit universal shift register.
// Expected results are queued when a command is issued and popped when done pulses.
// Build with SHIFT_SEQ_ARITH_EN defined to exercise the arithmetic-fill option.
module tb_shift_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       dir;
  logic       mode;
  logic       arith;
  logic [2:0] amount;
  logic [3:0] operand;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       carry;
  logic       sr_s1;
  logic       sr_s0;
  logic       sr_enable;
  logic [3:0] sr_parallelin;
  logic       sr_serialinr;
  logic       sr_serialinl;
  logic [3:0] sr_q;

  typedef struct {
    logic [3:0] res;
    logic       cy;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_total;
  int   n_pass;
  int   done_count;

  shift_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .dir            (dir),
    .mode           (mode),
`ifdef SHIFT_SEQ_ARITH_EN
    .arith          (arith),
`endif
    .amount         (amount),
    .operand        (operand),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .carry          (carry),
    .sr_s1          (sr_s1),
    .sr_s0          (sr_s0),
    .sr_enable      (sr_enable),
    .sr_parallelin  (sr_parallelin),
    .sr_serialinr   (sr_serialinr),
    .sr_serialinl   (sr_serialinl),
    .sr_parallelout (sr_q),
    .sr_serialoutr  (sr_q[0]),
    .sr_serialoutl  (sr_q[3])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream shift register: 00 hold, 01 right (fill bit 3), 10 left (fill bit 0), 11 load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sr_q <= 4'd0;
    else if (sr_enable) begin
      case ({sr_s1, sr_s0})
        2'b01:   sr_q <= {sr_serialinr, sr_q[3:1]};
        2'b10:   sr_q <= {sr_q[2:0], sr_serialinl};
        2'b11:   sr_q <= sr_parallelin;
        default: sr_q <= sr_q;
      endcase
    end
  end

  // Counts every done pulse, used to prove an abandoned command stays silent.
  always @(posedge clock) if (done) done_count <= done_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one command, queue its expected outcome, return #1 after the accepting edge.
  task automatic issue(input logic d, input logic m, input logic [2:0] a,
                       input logic [3:0] op, input logic [3:0] er, input logic ec);
    exp_t e;
    e.res = er;
    e.cy  = ec;
    e.lat = ((a > 3'd4) ? 4 : int'(a)) + 2;
    sb.push_back(e);
    dir = d; mode = m; amount = a; operand = op; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    $display("cmd op=%b dir=%0d mode=%0d amt=%0d", op, d, m, a);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("load_controls", 32'({sr_enable, sr_s1, sr_s0, sr_parallelin}), 32'({3'b111, op}));
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare.
  task automatic wait_done(input string tag);
    exp_t e;
    int   edges;
    logic seen;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(posedge clock); #1;
      edges++;
      if (done) seen = 1'b1;
    end
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
        $display("done %s result=%b carry=%0d edges=%0d", tag, result, carry, edges);
        check({tag, "_latency"}, 32'(edges), 32'(e.lat));
        check({tag, "_result"}, 32'(result), 32'(e.res));
        check({tag, "_carry"}, 32'(carry), 32'(e.cy));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic done_drops(input string tag);
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_total = 0; n_pass = 0; done_count = 0;
    reset_n = 1'b0; start = 1'b0; dir = 1'b0; mode = 1'b0;
    arith = 1'b0; amount = 3'd0; operand = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ctrl", 32'({sr_enable, sr_s1, sr_s0}), 32'd0);
    check("rst_fill", 32'({sr_serialinr, sr_serialinl}), 32'd0);
    check("rst_pin", 32'(sr_parallelin), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    issue(1'b0, 1'b0, 3'd1, 4'b1010, 4'b0101, 1'b0);
    wait_done("r_log_1");
    done_drops("r_log_1");

    issue(1'b1, 1'b1, 3'd2, 4'b1011, 4'b1110, 1'b0);
    wait_done("l_rot_2");

    issue(1'b1, 1'b0, 3'd7, 4'b1111, 4'b0000, 1'b1);
    wait_done("l_log_7");

    issue(1'b0, 1'b0, 3'd0, 4'b0110, 4'b0110, 1'b0);
    wait_done("amt_0");

    issue(1'b0, 1'b1, 3'd4, 4'b1001, 4'b1001, 1'b1);
    wait_done("r_rot_4");

    issue(1'b1, 1'b0, 3'd5, 4'b0001, 4'b0000, 1'b1);
    wait_done("l_log_5");

    // Back-to-back: second start is raised in the cycle done is high.
    issue(1'b1, 1'b0, 3'd3, 4'b0001, 4'b1000, 1'b0);
    wait_done("b2b_a");
    issue(1'b0, 1'b0, 3'd2, 4'b1110, 4'b0011, 1'b1);
    wait_done("b2b_b");

`ifdef SHIFT_SEQ_ARITH_EN
    arith = 1'b1;
    issue(1'b0, 1'b0, 3'd2, 4'b1000, 4'b1110, 1'b0);
    wait_done("r_arith_2");
    issue(1'b0, 1'b1, 3'd1, 4'b1000, 4'b0100, 1'b0);
    wait_done("r_rot_arith");
    issue(1'b1, 1'b0, 3'd1, 4'b1001, 4'b0010, 1'b1);
    wait_done("l_log_arith");
    arith = 1'b0;
`else
    issue(1'b0, 1'b0, 3'd2, 4'b1000, 4'b0010, 1'b0);
    wait_done("r_log_fill0");
`endif

    // Reset during SHIFT abandons the command.
    issue(1'b0, 1'b0, 3'd4, 4'b1111, 4'b0000, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre_rst_shift_carry", 32'(carry), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_enable", 32'(sr_enable), 32'd0);
    check("mid_rst_carry", 32'(carry), 32'd0);
    sb.delete();
    done_count = 0;
    @(negedge clock); reset_n = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("mid_rst_no_done", 32'(done_count), 32'd0);
    issue(1'b0, 1'b0, 3'd1, 4'b0011, 4'b0001, 1'b1);
    wait_done("post_rst");
    done_drops("post_rst");
    check("idle_ctrl", 32'({sr_enable, sr_s1, sr_s0}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have exactly one clock, `clock`, and one reset, `reset_n`; `reset_n` SHALL be asynchronous and active-low.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock, shared with the downstream 4-bit shift register.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe, sampled only in IDLE.
- dir  in  1  shift direction: 0 = right, 1 = left.
- mode  in  1  fill mode: 0 = logical, 1 = rotate.
- amount  in  3  requested shift count; values 5-7 are treated as 4.
- operand  in  4  value to be shifted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when `result` is valid.
- result  out  4  registered shifted value.
- carry  out  1  registered copy of the last bit shifted out.
- sr_s1, sr_s0  out  1 each  mode select to the shift register: 00 hold, 01 right, 10 left, 11 load.
- sr_enable  out  1  shift register enable.
- sr_parallelin  out  4  load value for the shift register.
- sr_serialinr, sr_serialinl  out  1 each  serial fill bits for right and left shifts.
- sr_parallelout  in  4  shift register contents.
- sr_serialoutr, sr_serialoutl  in  1 each  shift register bit 0 and bit 3.

Function
REQ-003 The state machine SHALL have the states IDLE, LOAD, SHIFT and CAPTURE, and all state changes SHALL occur on the rising edge of `clock`.
REQ-004 In IDLE, a rising edge with start=1 SHALL latch dir, mode, the saturated amount and operand, then move to LOAD; start SHALL be ignored in every other state.
REQ-005 LOAD SHALL drive {sr_s1,sr_s0}=11, sr_enable=1 and sr_parallelin=operand for one cycle, then go to SHIFT if the amount is nonzero, otherwise to CAPTURE.
REQ-006 SHIFT SHALL drive sr_enable=1 and {sr_s1,sr_s0}=01 for right or 10 for left.
REQ-007 SHIFT SHALL last for exactly `amount` cycles, counted down by a 3-bit counter, then go to CAPTURE.
REQ-008 CAPTURE SHALL drive {sr_s1,sr_s0}=00 with sr_enable=1, register result<=sr_parallelout, pulse done for one cycle and return to IDLE.
REQ-009 Latency: done SHALL be high in the cycle beginning amount+2 rising edges after the edge that accepted start.
REQ-010 Logical mode SHALL drive the active serial-fill output to 0 and SHALL never leave it undriven or X.
REQ-011 Rotate mode SHALL drive sr_serialinr=sr_serialoutr for right shifts and sr_serialinl=sr_serialoutl for left shifts, combinationally.
REQ-012 The serial-fill input that is not active SHALL be driven to 0.
REQ-013 On every SHIFT edge, carry SHALL capture the departing bit (sr_serialoutr for right, sr_serialoutl for left); for amount=0, carry SHALL be 0.
REQ-014 Boundary: amount≥4 in logical mode SHALL yield result=0000 and carry equal to the last bit shifted out.
REQ-015 Boundary: amount=4 in rotate mode SHALL yield result=operand.
REQ-016 Boundary: start asserted in the same cycle that done is high SHALL be accepted on the next edge, because the block is then in IDLE.
REQ-017 Outside LOAD, SHIFT and CAPTURE, sr_enable SHALL be 0 and {sr_s1,sr_s0} SHALL be 00.

Reset
REQ-018 Assertion of reset_n=0 SHALL immediately force IDLE and set busy, done, carry, sr_enable, sr_s1, sr_s0, sr_serialinr and sr_serialinl to 0.
REQ-019 Assertion of reset_n=0 SHALL immediately set result, sr_parallelin and the counter to 0.
REQ-020 A reset asserted mid-operation SHALL abandon the command without producing a done pulse.
REQ-021 After reset deasserts, the first start SHALL be processed normally.

Configuration
REQ-022 With `SHIFT_SEQ_ARITH_EN` defined, an extra input `arith` (1 bit) SHALL exist; when mode=0, dir=0 and arith=1, sr_serialinr SHALL be driven with latched operand[3] for every shift.
REQ-023 With `SHIFT_SEQ_ARITH_EN` defined, rotate mode SHALL override arith.
REQ-024 Without `SHIFT_SEQ_ARITH_EN`, the `arith` port SHALL be absent and logical right shifts SHALL fill with 0.

Verification
REQ-025 operand=1010, right, logical, amount=1 -> result=0101, carry=0, done 3 edges after start.
REQ-026 operand=1011, left, rotate, amount=2 -> result=1110, carry=0.
REQ-027 operand=0110, amount=0 -> result=0110, carry=0, done 2 edges after start, with no SHIFT cycles.
REQ-028 operand=1111, left, logical, amount=7 -> saturates to 4, result=0000, carry=1, done 6 edges after start.
REQ-029 reset_n pulsed low during SHIFT -> busy=0 and sr_enable=0 immediately, no done pulse; a following start with 0011, right, amount 1 -> result=0001, carry=1.
REQ-030 With SHIFT_SEQ_ARITH_EN: operand=1000, right, arith=1, amount=2 -> result=1110, carry=0.
